// File: rtl/sr_tap_sequencer_if.sv
// ----------------------------------------------------------------------------
// sr_tap_sequencer_if
// Bundles the sequencer's signals:
//   - sample strobe (ic_start)
//   - delay-line read port (oc_addr out, id_tap in)
//   - coefficient programming port (ic_coef_we, ic_coef_addr, id_coef)
//   - status and result (oc_busy, oc_overrun, od_y, oc_valid)
//
// Modports:
//   master - the sequencer itself.
//   slave  - its surroundings: delay line, coefficient writer and downstream
//            EQ stage.
// ----------------------------------------------------------------------------
interface sr_tap_sequencer_if #(
    parameter int IN_WIDTH   = 24,
    parameter int COEF_WIDTH = 24,
    parameter int NUM        = 3,
    parameter int OUT_WIDTH  = 24
);
    logic                         ic_start;
    logic        [NUM-1:0]        oc_addr;
    logic signed [IN_WIDTH-1:0]   id_tap;
    logic                         ic_coef_we;
    logic        [NUM-1:0]        ic_coef_addr;
    logic signed [COEF_WIDTH-1:0] id_coef;
    logic                         oc_busy;
    logic                         oc_overrun;
    logic signed [OUT_WIDTH-1:0]  od_y;
    logic                         oc_valid;

    modport master (
        input  ic_start, id_tap, ic_coef_we, ic_coef_addr, id_coef,
        output oc_addr, oc_busy, oc_overrun, od_y, oc_valid
    );

    modport slave (
        output ic_start, id_tap, ic_coef_we, ic_coef_addr, id_coef,
        input  oc_addr, oc_busy, oc_overrun, od_y, oc_valid
    );
endinterface

// File: rtl/sr_tap_sequencer.sv
// ----------------------------------------------------------------------------
// sr_tap_sequencer
// Purpose:
//   - On each sample strobe, reads taps 0..NUM-1 from the EQ delay line.
//     The delay line returns data one cycle after the address.
//   - Multiplies every returned tap by its coefficient from a writable table.
//   - Accumulates the products.
//   - Emits one rounded, saturated output sample with a one-cycle valid pulse.
//
// Ports:
//   ic_clk   - clock
//   ic_rst_n - asynchronous, active-low reset
//   bus      - sr_tap_sequencer_if.master:
//                ic_start, oc_addr/id_tap, coefficient write port,
//                oc_busy, oc_overrun, od_y, oc_valid
// ----------------------------------------------------------------------------
module sr_tap_sequencer #(
    parameter int IN_WIDTH   = 24,
    parameter int COEF_WIDTH = 24,
    parameter int NUM        = 3,
    parameter int COEF_FRAC  = 23,
    parameter int ACC_WIDTH  = 52,
    parameter int OUT_WIDTH  = 24
) (
    input logic              ic_clk,
    input logic              ic_rst_n,
    sr_tap_sequencer_if.master bus
);
    localparam int PW    = IN_WIDTH + COEF_WIDTH;
    localparam int CNT_W = $clog2(NUM + 3);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(NUM - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(NUM + 1);

    localparam logic signed [ACC_WIDTH:0] HALF =
        {{(ACC_WIDTH + 1 - COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC - 1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] OMAX =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OMIN =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // Round half up, then clamp to the signed output range. One guard bit
    // keeps the rounding add from wrapping at the top of the accumulator.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(
        input logic signed [ACC_WIDTH-1:0] a
    );
        logic signed [ACC_WIDTH:0] r;
        logic signed [ACC_WIDTH:0] s;
        r = {a[ACC_WIDTH-1], a} + HALF;
        s = r >>> COEF_FRAC;
        if (s > OMAX)
            s = OMAX;
        else if (s < OMIN)
            s = OMIN;
        return s[OUT_WIDTH-1:0];
    endfunction

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t                         state;
    logic        [CNT_W-1:0]        cnt;
    logic        [CNT_W-1:0]        cnt_nxt;
    logic signed [COEF_WIDTH-1:0]   coef [NUM];
    logic signed [COEF_WIDTH-1:0]   coef_sel;
    logic signed [PW-1:0]           prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc;

    // Index/valid pipe. vld_p0 marks a fresh address on oc_addr. vld_p1 and
    // idx_p1 line up with the tap data the delay line is returning now.
    logic                           vld_p0;
    logic                           vld_p1;
    logic        [NUM-1:0]          idx_p1;

    assign cnt_nxt = cnt + CNT_W'(1);

    always_comb begin
        coef_sel = '0;
        for (int i = 0; i < NUM; i++) begin
            if (idx_p1 == NUM'(i))
                coef_sel = coef[i];
        end
    end

    assign prod     = bus.id_tap * coef_sel;
    assign prod_ext = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

    // Coefficient table. A write to tap k lands before its read at E(k+2)
    // only if it happens on an earlier edge. Out-of-range indices match no
    // entry, so those writes are dropped.
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            for (int i = 0; i < NUM; i++)
                coef[i] <= '0;
        end else if (bus.ic_coef_we) begin
            for (int i = 0; i < NUM; i++) begin
                if (bus.ic_coef_addr == NUM'(i))
                    coef[i] <= bus.id_coef;
            end
        end
    end

    // Sweep control. cnt holds the index n of the last edge E(n) since the
    // strobe edge E0.
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            vld_p0         <= 1'b0;
            vld_p1         <= 1'b0;
            idx_p1         <= '0;
            bus.oc_addr    <= '0;
            bus.oc_busy    <= 1'b0;
            bus.oc_overrun <= 1'b0;
            bus.od_y       <= '0;
            bus.oc_valid   <= 1'b0;
        end else begin
            bus.oc_valid   <= 1'b0;
            bus.oc_overrun <= bus.ic_start && (state != IDLE);
            vld_p0         <= 1'b0;
            // stage p0 -> p1: tap addressed last cycle is being returned now
            vld_p1         <= vld_p0;
            idx_p1         <= bus.oc_addr;
            // stage p1 -> acc: returned tap times its coefficient
            if (vld_p1)
                acc <= acc + prod_ext;

            case (state)
                IDLE: begin
                    if (bus.ic_start) begin
                        state       <= ISSUE;
                        cnt         <= '0;
                        acc         <= '0;
                        bus.oc_addr <= '0;
                        bus.oc_busy <= 1'b1;
                        vld_p0      <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt <= LAST_ISSUE) begin
                        bus.oc_addr <= NUM'(cnt_nxt);
                        vld_p0      <= 1'b1;
                    end
                    // ">=" so that with NUM=1 ISSUE still lasts one cycle
                    if (cnt_nxt >= LAST_ISSUE)
                        state <= DRAIN;
                end
                DRAIN: begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == LAST_DRAIN)
                        state <= OUT;
                end
                OUT: begin
                    bus.od_y     <= round_sat(acc);
                    bus.oc_valid <= 1'b1;
                    bus.oc_busy  <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_tap_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sr_tap_sequencer
// Directed bench for sr_tap_sequencer.
//   - A behavioural delay line returns tap_mem[oc_addr] one cycle later.
//   - Expected outputs are queued when a sweep is started.
//   - Each oc_valid pulse pops one expected value and compares it with od_y.
// ----------------------------------------------------------------------------
module tb_sr_tap_sequencer;
    localparam int NUM = 3;

    logic ic_clk;
    logic ic_rst_n;

    sr_tap_sequencer_if #(.IN_WIDTH(24), .COEF_WIDTH(24), .NUM(NUM), .OUT_WIDTH(24)) bus ();

    sr_tap_sequencer #(
        .IN_WIDTH(24), .COEF_WIDTH(24), .NUM(NUM),
        .COEF_FRAC(23), .ACC_WIDTH(52), .OUT_WIDTH(24)
    ) dut (
        .ic_clk  (ic_clk),
        .ic_rst_n(ic_rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    logic signed [23:0] exp_q [$];
    logic signed [23:0] tap_mem [8];

    initial ic_clk = 1'b0;
    always #5 ic_clk = ~ic_clk;

    // Delay line: registered read, one cycle of latency.
    always @(posedge ic_clk) bus.id_tap <= tap_mem[bus.oc_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each valid pulse must match the oldest queued expectation.
    always @(negedge ic_clk) begin
        if (bus.oc_valid === 1'b1) begin
            n_valid++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid: observed=valid expected=none at %0t", $time);
            end
            if (exp_q.size() != 0) begin
                logic signed [23:0] e;
                e = exp_q.pop_front();
                check("od_y", 64'(bus.od_y), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ic_clk);
        #1;
    endtask

    task automatic write_coef(input logic [NUM-1:0] a, input logic signed [23:0] v);
        bus.ic_coef_we   = 1'b1;
        bus.ic_coef_addr = a;
        bus.id_coef      = v;
        tick();
        bus.ic_coef_we   = 1'b0;
    endtask

    task automatic set_coefs(input logic signed [23:0] c0, c1, c2);
        write_coef(3'd0, c0);
        write_coef(3'd1, c1);
        write_coef(3'd2, c2);
    endtask

    task automatic set_taps(input logic signed [23:0] t0, t1, t2);
        tap_mem[0] = t0;
        tap_mem[1] = t1;
        tap_mem[2] = t2;
    endtask

    // One strobe, then per-edge checks of oc_addr/oc_busy/oc_valid up to E(NUM+3).
    task automatic timed_sweep(input string tag, input logic signed [23:0] exp_y);
        exp_q.push_back(exp_y);
        bus.ic_start = 1'b1;
        tick();
        bus.ic_start = 1'b0;
        for (int c = 0; c <= NUM + 3; c++) begin
            if (c > 0) tick();
            check({tag, "_addr"},  64'(bus.oc_addr),  64'((c < NUM) ? c : NUM - 1));
            check({tag, "_busy"},  64'(bus.oc_busy),  64'(c < NUM + 2));
            check({tag, "_valid"}, 64'(bus.oc_valid), 64'(c == NUM + 2));
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 20 && bus.oc_busy; k++) tick();
        check({tag, "_idle_timeout"}, 64'(bus.oc_busy), 64'(0));
        tick();
    endtask

    initial begin
        int v0;
        ic_rst_n         = 1'b0;
        bus.ic_start     = 1'b0;
        bus.ic_coef_we   = 1'b0;
        bus.ic_coef_addr = '0;
        bus.id_coef      = '0;
        for (int i = 0; i < 8; i++) tap_mem[i] = '0;
        set_taps(24'sd1000, 24'sd2000, -24'sd4000);

        // Reset state
        tick();
        tick();
        check("rst_addr", 64'(bus.oc_addr), 64'(0));
        check("rst_busy", 64'(bus.oc_busy), 64'(0));
        check("rst_valid", 64'(bus.oc_valid), 64'(0));
        check("rst_y", 64'(bus.od_y), 64'(0));
        ic_rst_n = 1'b1;
        tick();
        tick();
        check("idle_addr", 64'(bus.oc_addr), 64'(0));
        check("idle_busy", 64'(bus.oc_busy), 64'(0));
        check("idle_overrun", 64'(bus.oc_overrun), 64'(0));
        check("idle_y", 64'(bus.od_y), 64'(0));

        // All coefficients zero
        timed_sweep("zero", 24'sd0);

        // Main function: 0.5, 0.25, 0.5
        set_coefs(24'sh400000, 24'sh200000, 24'sh400000);
        timed_sweep("main", -24'sd1000);

        // Saturation, both rails
        set_coefs(24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF);
        set_taps(24'sh7FFFFF, 24'sh7FFFFF, 24'sh7FFFFF);
        timed_sweep("sat_pos", 24'sh7FFFFF);
        set_taps(24'sh800000, 24'sh800000, 24'sh800000);
        timed_sweep("sat_neg", 24'sh800000);

        // Rounding at exactly half an LSB
        set_coefs(24'sh000001, 24'sh0, 24'sh0);
        set_taps(24'sh400000, 24'sd5, 24'sd7);
        timed_sweep("round_up", 24'sd1);
        set_taps(-24'sh400000, 24'sd5, 24'sd7);
        timed_sweep("round_neg", 24'sd0);

        // Overrun: second strobe at E2 is dropped; a strobe at E(NUM+3) is taken
        set_coefs(24'sh400000, 24'sh200000, 24'sh400000);
        set_taps(24'sd1000, 24'sd2000, -24'sd4000);
        v0 = n_valid;
        exp_q.push_back(-24'sd1000);
        bus.ic_start = 1'b1;
        tick();                                   // E0
        bus.ic_start = 1'b0;
        tick();                                   // E1
        bus.ic_start = 1'b1;
        tick();                                   // E2
        bus.ic_start = 1'b0;
        check("ovr_pulse", 64'(bus.oc_overrun), 64'(1));
        tick();                                   // E3
        check("ovr_clear", 64'(bus.oc_overrun), 64'(0));
        tick();                                   // E4
        tick();                                   // E5
        check("ovr_valid", 64'(bus.oc_valid), 64'(1));
        exp_q.push_back(-24'sd1000);
        bus.ic_start = 1'b1;
        tick();                                   // E6 = E(NUM+3)
        bus.ic_start = 1'b0;
        check("ovr_restart_busy", 64'(bus.oc_busy), 64'(1));
        check("ovr_restart_addr", 64'(bus.oc_addr), 64'(0));
        wait_idle("ovr");
        check("ovr_valid_count", 64'(n_valid - v0), 64'(2));

        // Asynchronous reset in the middle of ISSUE
        v0 = n_valid;
        bus.ic_start = 1'b1;
        tick();                                   // E0
        bus.ic_start = 1'b0;
        tick();                                   // E1
        #2;
        ic_rst_n = 1'b0;
        #1;
        check("arst_addr", 64'(bus.oc_addr), 64'(0));
        check("arst_busy", 64'(bus.oc_busy), 64'(0));
        check("arst_y", 64'(bus.od_y), 64'(0));
        check("arst_valid", 64'(bus.oc_valid), 64'(0));
        tick();
        tick();
        tick();
        ic_rst_n = 1'b1;
        tick();
        check("arst_no_valid", 64'(n_valid - v0), 64'(0));

        // Coefficients were cleared by the reset
        timed_sweep("arst_cleared", 24'sd0);

        // New coefficients; an out-of-range write must not disturb the table
        set_coefs(24'sh100000, 24'sh100000, 24'sh100000);
        write_coef(3'd4, 24'sh7FFFFF);
        set_taps(24'sd8000, -24'sd16000, 24'sd800);
        timed_sweep("post_rst", -24'sd900);

        tick();
        check("scoreboard_drain", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
